fetch_stage: RTL

Instruction fetch stage of the 5-stage 64-bit pipelined CPU, sitting upstream of decode and owning the PC and IF/ID register. It issues one-outstanding requests to a variable-latency instruction memory and buffers returned words in a small FIFO. It presents {pc, instr, valid} to decode, honours decode stall, and flushes on a taken-branch redirect from EX/MEM (`Branch & Z`, target = jump adder output).

---
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel,
// EX/MEM redirect, decode stall and the IF/ID register outputs.
//   master : fetch stage side (drives imem_req/imem_addr and IF/ID)
//   slave  : environment side (memory, EX/MEM redirect, decode)
interface fetch_stage_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        id_stall;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;

  modport master (
    output imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, id_stall
  );

  modport slave (
    input  imem_req, imem_addr, ifid_valid, ifid_pc, ifid_instr,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, id_stall
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, keeps one request outstanding
// to a variable-latency instruction memory, buffers returned words in a
// small FIFO and feeds the IF/ID register. A taken-branch redirect flushes
// everything and restarts fetch at redirect_pc.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : fetch_stage_if.master (imem channel, redirect, id_stall, IF/ID)
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t             state_q;
  logic [63:0]        fetch_pc_q;
  logic [63:0]        tag_q;
  fifo_entry_t        fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               ifid_valid_q;
  logic [63:0]        ifid_pc_q;
  logic [31:0]        ifid_instr_q;

  logic               wr_c;
  logic               pop_c;
  logic               space_c;
  logic               fsm_ok_c;
  logic               req_c;
  logic               accept_c;
  fifo_entry_t        head_c;

  // Occupancy after this cycle's push/pop decides whether a new request
  // can be launched without risking a response with nowhere to go.
  always_comb begin
    wr_c     = (state_q == S_WAIT) && bus.imem_rvalid && !bus.redirect;
    pop_c    = (count_q != '0) && !bus.id_stall && !bus.redirect;
    count_d  = count_q + CNT_W'(wr_c) - CNT_W'(pop_c);
    space_c  = count_d < CNT_W'(FIFO_DEPTH);
    fsm_ok_c = (state_q == S_IDLE) || bus.imem_rvalid;
    req_c    = !rst && !bus.redirect && space_c && fsm_ok_c;
    accept_c = req_c && bus.imem_ready;
    head_c   = fifo_q[rd_ptr_q];
  end

  assign bus.imem_req   = req_c;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_instr = ifid_instr_q;

  // FIFO storage; contents are qualified by count_q so they need no reset.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      fifo_q[wr_ptr_q] <= '{pc: tag_q, instr: bus.imem_rdata};
    end
  end

  // Request FSM, fetch PC, FIFO pointers and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      tag_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= '0;
    end else begin
      if (bus.redirect) begin
        fetch_pc_q <= bus.redirect_pc;
      end else if (accept_c) begin
        fetch_pc_q <= fetch_pc_q + 64'd4;
      end

      if (accept_c) begin
        tag_q <= fetch_pc_q;
      end

      unique case (state_q)
        S_IDLE: begin
          if (accept_c) state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A redirect racing the response drops it outright; otherwise the
          // response is still owed and must be swallowed in DISCARD.
          if (bus.redirect) begin
            state_q <= bus.imem_rvalid ? S_IDLE : S_DISCARD;
          end else if (bus.imem_rvalid) begin
            state_q <= accept_c ? S_WAIT : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (bus.imem_rvalid) begin
            state_q <= accept_c ? S_WAIT : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (bus.redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_d;
      end

      if (bus.redirect) begin
        ifid_valid_q <= 1'b0;
      end else if (bus.id_stall) begin
        ifid_valid_q <= ifid_valid_q;
      end else if (count_q != '0) begin
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= head_c.pc;
        ifid_instr_q <= head_c.instr;
      end else begin
        ifid_valid_q <= 1'b0;
      end
    end
  end

endmodule
